// File: rtl/rb_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : rb_ctrl_param
// Brief    : BRAM row-buffer sequencer (fill, prime, run) with start/busy,
//            stall and abort. Optional stall counter under RB_STALL_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module rb_ctrl_param #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int N_BUF = 4,
    localparam int SEL_W = ($clog2(N_BUF) > 1) ? $clog2(N_BUF) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             stall,
    output logic             busy,
    output logic             complete,
    output logic             en_e_mem_addr,
    output logic             en_w_bram_addr,
    output logic             en_r_bram_addr,
    output logic             en_a,
    output logic             en_b,
    output logic [SEL_W-1:0] steer,
    output logic             steer_en
`ifdef RB_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int FILL_LEN  = N_BUF * IMG_W + 1;
    localparam int RUN_LEN   = IMG_W * (IMG_H - N_BUF);
    localparam int PTR_DEPTH = N_BUF * IMG_W;
    localparam int FILL_W    = $clog2(FILL_LEN);
    localparam int RUN_W     = $clog2(RUN_LEN);
    localparam int PTR_W     = $clog2(PTR_DEPTH);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_LEN - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_LEN - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(PTR_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_PRIME = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [RUN_W-1:0]  rw_cnt_q, rw_cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic              launch;

    // A frame can only be launched from a quiescent state; abort vetoes it.
    assign launch     = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !abort;
    assign rd_ptr_inc = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    assign steer      = rd_ptr_q[PTR_W-1 -: SEL_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fill_cnt_q <= '0;
            rw_cnt_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            rw_cnt_q   <= rw_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        fill_cnt_d     = fill_cnt_q;
        rw_cnt_d       = rw_cnt_q;
        rd_ptr_d       = rd_ptr_q;
        busy           = 1'b0;
        complete       = 1'b0;
        en_e_mem_addr  = 1'b0;
        en_w_bram_addr = 1'b0;
        en_r_bram_addr = 1'b0;
        en_a           = 1'b0;
        en_b           = 1'b0;
        steer_en       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                complete = (state_q == S_DONE);
                if (start) begin
                    state_d    = S_FILL;
                    fill_cnt_d = '0;
                    rw_cnt_d   = '0;
                    rd_ptr_d   = '0;
                end
            end
            S_FILL: begin
                busy = 1'b1;
                if (!stall) begin
                    en_e_mem_addr  = 1'b1;
                    en_w_bram_addr = 1'b1;
                    en_a           = 1'b1;
                    fill_cnt_d     = fill_cnt_q + FILL_W'(1);
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d = S_PRIME;
                    end
                end
            end
            S_PRIME: begin
                busy = 1'b1;
                if (!stall) begin
                    en_r_bram_addr = 1'b1;
                    en_b           = 1'b1;
                    steer_en       = 1'b1;
                    rd_ptr_d       = rd_ptr_inc;
                    state_d        = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (!stall) begin
                    en_e_mem_addr  = 1'b1;
                    en_w_bram_addr = 1'b1;
                    en_r_bram_addr = 1'b1;
                    en_a           = 1'b1;
                    en_b           = 1'b1;
                    steer_en       = 1'b1;
                    rd_ptr_d       = rd_ptr_inc;
                    rw_cnt_d       = rw_cnt_q + RUN_W'(1);
                    if (rw_cnt_q == RUN_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            fill_cnt_d = '0;
            rw_cnt_d   = '0;
            rd_ptr_d   = '0;
        end
    end

`ifdef RB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (launch) begin
            stall_cnt_d = '0;
        end else if (busy && stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    // Without stall accounting the launch qualifier has no consumer.
    logic launch_unused;
    assign launch_unused = launch;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rb_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rb_ctrl_param
// Brief    : Directed self-checking bench for rb_ctrl_param (8x8/4-row and
//            16x16/2-row instances sharing clock, reset and controls).
// Revision : 1.0  initial release
// ============================================================================
module tb_rb_ctrl_param;

    logic clk = 1'b0;
    logic rst_n, start, abort, stall;

    logic a_busy, a_complete, a_en_e, a_en_w, a_en_r, a_en_a, a_en_b, a_steer_en;
    logic [1:0] a_steer;
    logic b_busy, b_complete, b_en_e, b_en_w, b_en_r, b_en_a, b_en_b, b_steer_en;
    logic [0:0] b_steer;
`ifdef RB_STALL_CNT_EN
    logic [31:0] a_stall_cycles, b_stall_cycles;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rb_ctrl_param #(.IMG_W(8), .IMG_H(8), .N_BUF(4)) u_dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .stall          (stall),
        .busy           (a_busy),
        .complete       (a_complete),
        .en_e_mem_addr  (a_en_e),
        .en_w_bram_addr (a_en_w),
        .en_r_bram_addr (a_en_r),
        .en_a           (a_en_a),
        .en_b           (a_en_b),
        .steer          (a_steer),
        .steer_en       (a_steer_en)
`ifdef RB_STALL_CNT_EN
        ,
        .stall_cycles   (a_stall_cycles)
`endif
    );

    rb_ctrl_param #(.IMG_W(16), .IMG_H(16), .N_BUF(2)) u_dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .stall          (stall),
        .busy           (b_busy),
        .complete       (b_complete),
        .en_e_mem_addr  (b_en_e),
        .en_w_bram_addr (b_en_w),
        .en_r_bram_addr (b_en_r),
        .en_a           (b_en_a),
        .en_b           (b_en_b),
        .steer          (b_steer),
        .steer_en       (b_steer_en)
`ifdef RB_STALL_CNT_EN
        ,
        .stall_cycles   (b_stall_cycles)
`endif
    );

    // Starts a frame and walks it to DONE, tallying phases and flagging any
    // cycle whose outputs disagree with the expected phase or steer value.
    task automatic run_frame(input bit which, input int sp,
                             input int s1, input int l1, input int s2, input int l2,
                             output int n_fill, output int n_prime, output int n_run,
                             output int n_stall, output int edges, output int bad);
        int  w;
        int  p;
        int  st;
        bit  done;
        logic bz, cp, ee, ew, er, ea, eb, se;
        w = which ? 16 : 8;
        p = 0;
        n_fill = 0; n_prime = 0; n_run = 0; n_stall = 0; edges = 0; bad = 0;
        done = 1'b0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        while (!done) begin
            stall = ((edges >= s1) && (edges < s1 + l1)) || ((edges >= s2) && (edges < s2 + l2));
            start = (edges == sp);
            #1;
            if (which) begin
                bz = b_busy; cp = b_complete; ee = b_en_e; ew = b_en_w;
                er = b_en_r; ea = b_en_a; eb = b_en_b; se = b_steer_en; st = int'(b_steer);
            end else begin
                bz = a_busy; cp = a_complete; ee = a_en_e; ew = a_en_w;
                er = a_en_r; ea = a_en_a; eb = a_en_b; se = a_steer_en; st = int'(a_steer);
            end
            if (cp === 1'b1) begin
                done = 1'b1;
            end else begin
                if (bz !== 1'b1) bad++;
                if ((ee !== ea) || (ew !== ea) || (er !== eb) || (se !== eb)) bad++;
                if (stall) begin
                    n_stall++;
                    if ((ea !== 1'b0) || (eb !== 1'b0)) bad++;
                end else if (ea === 1'b1 && eb === 1'b0) begin
                    n_fill++;
                    if (st != 0 || n_prime != 0 || n_run != 0) bad++;
                end else if (ea === 1'b0 && eb === 1'b1) begin
                    n_prime++;
                    if (st != p / w || n_run != 0) bad++;
                    p = (p + 1) % 32;
                end else if (ea === 1'b1 && eb === 1'b1) begin
                    n_run++;
                    if (st != p / w) bad++;
                    p = (p + 1) % 32;
                end else begin
                    bad++;
                end
                if (edges >= 400) begin
                    bad++;
                    $display("FAIL run_frame_timeout: edges=%0d without complete, required < 400", edges);
                    done = 1'b1;
                end else begin
                    @(posedge clk); #2;
                    edges++;
                end
            end
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_total++;
        if ({a_busy, a_complete, a_en_e, a_en_w, a_en_r, a_en_a, a_en_b, a_steer_en, a_steer} !== 10'd0)
            $display("FAIL reset_a_outputs: got %b, expected 0",
                     {a_busy, a_complete, a_en_e, a_en_w, a_en_r, a_en_a, a_en_b, a_steer_en, a_steer});
        else n_pass++;
        n_total++;
        if ({b_busy, b_complete, b_en_e, b_en_w, b_en_r, b_en_a, b_en_b, b_steer_en, b_steer} !== 9'd0)
            $display("FAIL reset_b_outputs: got %b, expected 0",
                     {b_busy, b_complete, b_en_e, b_en_w, b_en_r, b_en_a, b_en_b, b_steer_en, b_steer});
        else n_pass++;
`ifdef RB_STALL_CNT_EN
        n_total++;
        if (a_stall_cycles !== 32'd0)
            $display("FAIL reset_stall_cycles: got %0d, expected 0", a_stall_cycles);
        else n_pass++;
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_total++;
        if ({a_busy, a_complete, a_en_a, a_en_b} !== 4'd0)
            $display("FAIL idle_after_reset: got %b, expected 0000", {a_busy, a_complete, a_en_a, a_en_b});
        else n_pass++;
    endtask

    task automatic test_frame();
        int nf, np, nr, ns, ed, bad, hold_bad;
        run_frame(1'b0, -1, -1, 0, -1, 0, nf, np, nr, ns, ed, bad);
        n_total++;
        if (nf !== 33) $display("FAIL frame_fill_cycles: got %0d, expected 33", nf); else n_pass++;
        n_total++;
        if (np !== 1) $display("FAIL frame_prime_cycles: got %0d, expected 1", np); else n_pass++;
        n_total++;
        if (nr !== 32) $display("FAIL frame_run_cycles: got %0d, expected 32", nr); else n_pass++;
        n_total++;
        if (ed !== 66) $display("FAIL frame_complete_edge: got %0d, expected 66", ed); else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL frame_cycle_errors: got %0d, expected 0", bad); else n_pass++;
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #3;
            if ({a_complete, a_busy, a_en_a, a_en_b, a_steer_en, a_steer} !== 7'b1000000) hold_bad++;
        end
        n_total++;
        if (hold_bad !== 0) $display("FAIL done_hold: got %0d bad cycles, expected 0", hold_bad); else n_pass++;
`ifdef RB_STALL_CNT_EN
        n_total++;
        if (a_stall_cycles !== 32'd0) $display("FAIL frame_stall_cycles: got %0d, expected 0", a_stall_cycles);
        else n_pass++;
`endif
    endtask

    task automatic test_steer_trace();
        int tr[33];
        int mis;
        bit found;
        found = 1'b0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (a_en_b === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        n_total++;
        if (!found) $display("FAIL steer_prime_seen: got 0, expected 1"); else n_pass++;
        for (int j = 0; j < 33; j++) begin
            if (j > 0) begin
                @(posedge clk); #3;
            end
            tr[j] = int'(a_steer);
        end
        mis = 0;
        for (int j = 0; j < 33; j++) if (tr[j] != (j % 32) / 8) mis++;
        n_total++;
        if (tr[7] !== 0) $display("FAIL steer_ptr7: got %0d, expected 0", tr[7]); else n_pass++;
        n_total++;
        if (tr[8] !== 1) $display("FAIL steer_ptr8: got %0d, expected 1", tr[8]); else n_pass++;
        n_total++;
        if (tr[16] !== 2) $display("FAIL steer_ptr16: got %0d, expected 2", tr[16]); else n_pass++;
        n_total++;
        if (tr[31] !== 3) $display("FAIL steer_ptr31: got %0d, expected 3", tr[31]); else n_pass++;
        n_total++;
        if (tr[32] !== 0) $display("FAIL steer_wrap: got %0d, expected 0", tr[32]); else n_pass++;
        n_total++;
        if (mis !== 0) $display("FAIL steer_trace: got %0d mismatching cycles, expected 0", mis); else n_pass++;
        @(posedge clk); #3;
        n_total++;
        if (a_complete !== 1'b1) $display("FAIL steer_frame_done: got %b, expected 1", a_complete); else n_pass++;
    endtask

    task automatic test_stall();
        int nf, np, nr, ns, ed, bad;
        run_frame(1'b0, -1, 10, 5, 50, 3, nf, np, nr, ns, ed, bad);
        n_total++;
        if (ed !== 74) $display("FAIL stall_complete_edge: got %0d, expected 74", ed); else n_pass++;
        n_total++;
        if (ns !== 8) $display("FAIL stall_cycle_count: got %0d, expected 8", ns); else n_pass++;
        n_total++;
        if (nf !== 33 || nr !== 32 || np !== 1)
            $display("FAIL stall_phase_lengths: got %0d/%0d/%0d, expected 33/1/32", nf, np, nr);
        else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL stall_cycle_errors: got %0d, expected 0", bad); else n_pass++;
`ifdef RB_STALL_CNT_EN
        n_total++;
        if (a_stall_cycles !== 32'd8) $display("FAIL stall_cycles_done: got %0d, expected 8", a_stall_cycles);
        else n_pass++;
`endif
    endtask

    task automatic test_abort();
        int nf, np, nr, ns, ed, bad;
        int runidx;
        bit hit;
        runidx = 0;
        hit = 1'b0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (a_en_a === 1'b1 && a_en_b === 1'b1) begin
                if (runidx == 10) begin
                    hit = 1'b1;
                    break;
                end
                runidx++;
            end
            @(posedge clk); #2;
        end
        n_total++;
        if (!hit || a_steer !== 2'd1)
            $display("FAIL abort_precondition: got hit=%b steer=%0d, expected hit=1 steer=1", hit, a_steer);
        else n_pass++;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        #1;
        n_total++;
        if ({a_busy, a_complete, a_en_e, a_en_w, a_en_r, a_en_a, a_en_b, a_steer_en, a_steer} !== 10'd0)
            $display("FAIL abort_outputs: got %b, expected 0",
                     {a_busy, a_complete, a_en_e, a_en_w, a_en_r, a_en_a, a_en_b, a_steer_en, a_steer});
        else n_pass++;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
        #1;
        n_total++;
        if (a_busy !== 1'b0) $display("FAIL start_with_abort: got busy=%b, expected 0", a_busy); else n_pass++;
        run_frame(1'b0, -1, -1, 0, -1, 0, nf, np, nr, ns, ed, bad);
        n_total++;
        if (ed !== 66 || bad !== 0)
            $display("FAIL abort_restart_frame: got edges=%0d errors=%0d, expected 66/0", ed, bad);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int nf, np, nr, ns, ed, bad;
        run_frame(1'b0, 5, -1, 0, -1, 0, nf, np, nr, ns, ed, bad);
        n_total++;
        if (ed !== 66 || nf !== 33 || bad !== 0)
            $display("FAIL start_in_fill: got edges=%0d fill=%0d errors=%0d, expected 66/33/0", ed, nf, bad);
        else n_pass++;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        #1;
        n_total++;
        if ({a_complete, a_busy, a_en_a, a_en_b} !== 4'b0110)
            $display("FAIL start_in_done: got %b, expected 0110", {a_complete, a_busy, a_en_a, a_en_b});
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int nf, np, nr, ns, ed, bad;
        repeat (45) @(posedge clk);
        #2;
        n_total++;
        if ({a_en_a, a_en_b} !== 2'b11) $display("FAIL reset_pre_run: got %b, expected 11", {a_en_a, a_en_b});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({a_busy, a_complete, a_en_e, a_en_w, a_en_r, a_en_a, a_en_b, a_steer_en, a_steer} !== 10'd0)
            $display("FAIL async_reset_outputs: got %b, expected 0",
                     {a_busy, a_complete, a_en_e, a_en_w, a_en_r, a_en_a, a_en_b, a_steer_en, a_steer});
        else n_pass++;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #3;
        n_total++;
        if ({a_busy, b_busy, a_complete, b_complete} !== 4'd0)
            $display("FAIL idle_after_async_reset: got %b, expected 0000", {a_busy, b_busy, a_complete, b_complete});
        else n_pass++;
        run_frame(1'b1, -1, -1, 0, -1, 0, nf, np, nr, ns, ed, bad);
        n_total++;
        if (nf !== 33 || np !== 1 || nr !== 224)
            $display("FAIL b_phase_lengths: got %0d/%0d/%0d, expected 33/1/224", nf, np, nr);
        else n_pass++;
        n_total++;
        if (ed !== 258 || bad !== 0)
            $display("FAIL b_frame: got edges=%0d errors=%0d, expected 258/0", ed, bad);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_steer_trace();
        test_stall();
        test_abort();
        test_start_ignored();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
